// File: rtl/memory_access_stage_if.sv
// Purpose : data-memory request/ack bus between the MEM stage (master) and data memory (slave).
// Latency : pure wiring, no state.
// Backpressure : the master holds dm_req and the request fields until the slave answers with dm_ack.
// Ports (signals): dm_req, dm_we, dm_addr[31:0], dm_wdata[31:0], dm_be[3:0]  master -> slave
//                  dm_ack, dm_rdata[31:0]                                     slave  -> master
interface memory_access_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/memory_access_stage.sv
// Purpose : RV32I MEM stage - issues data-memory accesses, formats store lanes, extracts/extends
//           load data and registers the MEM/WB bundle for write_back_stage.
// Latency : 1 cycle for non-memory ops and zero-wait accesses; otherwise 1 cycle after dm_ack.
// Backpressure : stall_mem is high while an access waits for dm_ack; MEM/WB captures bubbles meanwhile.
// Ports: clk_mem, rst_mem (sync, active-high); EX/MEM inputs valid_mem, flush_mem, pc_next_mem,
//        ALU_res_mem, rs2_data_mem, rd_mem, RU_DM_write_src_mem, RUwrite_mem, DMwrite_mem, DMctrl_mem;
//        dm (memory_access_stage_if.master) data-memory bus; stall_mem; MEM/WB outputs pc_next_wb,
//        ALU_res_wb, DM_data_rd_wb, rd_wb, RU_DM_write_src_wb, RUwrite_wb.
// Optional: define MISALIGN_TRAP_EN to add misalign_trap_wb and suppress misaligned H/W accesses.
module memory_access_stage #(
  parameter int unsigned XLEN    = 32,
  parameter logic [1:0]  NEXT_PC = 2'b10,
  parameter logic [1:0]  DM_READ = 2'b01,
  parameter logic [1:0]  ALU_RES = 2'b00
) (
  input  logic                  clk_mem,
  input  logic                  rst_mem,
  input  logic                  valid_mem,
  input  logic                  flush_mem,
  input  logic [XLEN-1:0]       pc_next_mem,
  input  logic [XLEN-1:0]       ALU_res_mem,
  input  logic [XLEN-1:0]       rs2_data_mem,
  input  logic [4:0]            rd_mem,
  input  logic [1:0]            RU_DM_write_src_mem,
  input  logic                  RUwrite_mem,
  input  logic                  DMwrite_mem,
  input  logic [2:0]            DMctrl_mem,
  memory_access_stage_if.master dm,
  output logic                  stall_mem,
  output logic [XLEN-1:0]       pc_next_wb,
  output logic [XLEN-1:0]       ALU_res_wb,
  output logic [XLEN-1:0]       DM_data_rd_wb,
  output logic [4:0]            rd_wb,
  output logic [1:0]            RU_DM_write_src_wb,
  output logic                  RUwrite_wb
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                  misalign_trap_wb
`endif
);

  // Access size lives in funct3[1:0]; funct3[2] selects zero-extension.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  size;
  logic        uns;
  logic [1:0]  a_lo;
  logic        is_load;
  logic        memop;
  logic        misalign;
  logic        issue;
  logic        trap_now;
  logic        req_c;
  logic        stall_c;
  logic        commit;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [1:0]  src_sane;

  assign size    = DMctrl_mem[1:0];
  assign uns     = DMctrl_mem[2];
  assign a_lo    = ALU_res_mem[1:0];
  assign is_load = (RU_DM_write_src_mem == DM_READ);
  assign memop   = valid_mem & ~flush_mem & (DMwrite_mem | is_load);

`ifdef MISALIGN_TRAP_EN
  // Halfword (H/HU) on an odd address, or word on a non-word boundary.
  assign misalign = ((size == SZ_H) & a_lo[0]) | ((size == 2'b10) & (a_lo != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign issue    = memop & ~misalign;
  // Traps are only decided in IDLE; WAIT is entered only for aligned accesses.
  assign trap_now = (state_q == S_IDLE) & memop & misalign;

  // Encodings outside the three known write-back sources collapse to the ALU result.
  assign src_sane = ((RU_DM_write_src_mem == NEXT_PC) || (RU_DM_write_src_mem == DM_READ)) ?
                    RU_DM_write_src_mem : ALU_RES;

  // ---------------------------------------------------------------- store lanes
  always_comb begin
    st_wdata = rs2_data_mem[31:0];
    st_be    = 4'b1111;
    case (size)
      SZ_B: begin
        st_wdata = {4{rs2_data_mem[7:0]}};
        st_be    = 4'b0001 << a_lo;
      end
      SZ_H: begin
        st_wdata = {2{rs2_data_mem[15:0]}};
        st_be    = a_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = rs2_data_mem[31:0];
        st_be    = 4'b1111;
      end
    endcase
  end

  // ---------------------------------------------------------------- load extract
  assign ld_byte = dm.dm_rdata[{a_lo, 3'b000} +: 8];
  assign ld_half = a_lo[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];

  always_comb begin
    ld_data = dm.dm_rdata;
    case (size)
      SZ_B:    ld_data = {{24{~uns & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{~uns & ld_half[15]}}, ld_half};
      default: ld_data = dm.dm_rdata;
    endcase
  end

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk_mem) begin
    if (rst_mem) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue && !dm.dm_ack) state_d = S_WAIT;
      S_WAIT:  if (dm.dm_ack)           state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  // Reset masks the request immediately so a reset taken mid-WAIT never leaves
  // a request hanging on the bus while rst_mem is still high.
  always_comb begin
    req_c   = 1'b0;
    stall_c = 1'b0;
    commit  = 1'b0;
    if (!rst_mem) begin
      case (state_q)
        S_IDLE: begin
          req_c   = issue;
          stall_c = issue & ~dm.dm_ack;
          commit  = valid_mem & ~flush_mem & ~(issue & ~dm.dm_ack);
        end
        S_WAIT: begin
          // Flush is ignored here: the outstanding access must complete.
          req_c   = 1'b1;
          stall_c = ~dm.dm_ack;
          commit  = dm.dm_ack;
        end
        default: begin
          req_c   = 1'b0;
          stall_c = 1'b0;
          commit  = 1'b0;
        end
      endcase
    end
  end

  // Request fields come straight from EX/MEM; the stall keeps them stable in WAIT.
  assign dm.dm_req   = req_c;
  assign dm.dm_we    = req_c & DMwrite_mem;
  assign dm.dm_addr  = {ALU_res_mem[31:2], 2'b00};
  assign dm.dm_wdata = st_wdata;
  assign dm.dm_be    = !req_c ? 4'b0000 : (DMwrite_mem ? st_be : 4'b1111);
  assign stall_mem   = stall_c;

  // ---------------------------------------------------------------- MEM/WB bundle
  always_ff @(posedge clk_mem) begin
    if (rst_mem) begin
      pc_next_wb         <= '0;
      ALU_res_wb         <= '0;
      DM_data_rd_wb      <= '0;
      rd_wb              <= '0;
      RU_DM_write_src_wb <= '0;
      RUwrite_wb         <= 1'b0;
    end else if (commit) begin
      pc_next_wb         <= pc_next_mem;
      ALU_res_wb         <= ALU_res_mem;
      DM_data_rd_wb      <= is_load ? ld_data : '0;
      rd_wb              <= rd_mem;
      RU_DM_write_src_wb <= src_sane;
      // x0 is never written; a trapped access must not update the register file.
      RUwrite_wb         <= RUwrite_mem & (rd_mem != 5'd0) & ~trap_now;
    end else begin
      // Bubble: stalled, flushed or empty slot.
      pc_next_wb         <= '0;
      ALU_res_wb         <= '0;
      DM_data_rd_wb      <= '0;
      rd_wb              <= '0;
      RU_DM_write_src_wb <= ALU_RES;
      RUwrite_wb         <= 1'b0;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk_mem) begin
    if (rst_mem) begin
      misalign_trap_wb <= 1'b0;
    end else begin
      misalign_trap_wb <= commit & trap_now;
    end
  end
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
// Purpose : self-checking bench for memory_access_stage; random instruction stream plus directed cases.
// Latency : model predicts the MEM/WB bundle one edge after each commit, bubbles on stall cycles.
// Backpressure : the bench plays the data memory and chooses the ack delay of every access.
module tb_memory_access_stage;

  logic        clk_mem = 1'b0;
  logic        rst_mem;
  logic        valid_mem, flush_mem;
  logic [31:0] pc_next_mem, ALU_res_mem, rs2_data_mem;
  logic [4:0]  rd_mem;
  logic [1:0]  RU_DM_write_src_mem;
  logic        RUwrite_mem, DMwrite_mem;
  logic [2:0]  DMctrl_mem;
  logic        stall_mem;
  logic [31:0] pc_next_wb, ALU_res_wb, DM_data_rd_wb;
  logic [4:0]  rd_wb;
  logic [1:0]  RU_DM_write_src_wb;
  logic        RUwrite_wb;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_trap_wb;
`endif

  memory_access_stage_if dm_bus();

  memory_access_stage dut (
    .clk_mem             (clk_mem),
    .rst_mem             (rst_mem),
    .valid_mem           (valid_mem),
    .flush_mem           (flush_mem),
    .pc_next_mem         (pc_next_mem),
    .ALU_res_mem         (ALU_res_mem),
    .rs2_data_mem        (rs2_data_mem),
    .rd_mem              (rd_mem),
    .RU_DM_write_src_mem (RU_DM_write_src_mem),
    .RUwrite_mem         (RUwrite_mem),
    .DMwrite_mem         (DMwrite_mem),
    .DMctrl_mem          (DMctrl_mem),
    .dm                  (dm_bus),
    .stall_mem           (stall_mem),
    .pc_next_wb          (pc_next_wb),
    .ALU_res_wb          (ALU_res_wb),
    .DM_data_rd_wb       (DM_data_rd_wb),
    .rd_wb               (rd_wb),
    .RU_DM_write_src_wb  (RU_DM_write_src_wb),
    .RUwrite_wb          (RUwrite_wb)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_trap_wb    (misalign_trap_wb)
`endif
  );

  always #5 clk_mem = ~clk_mem;

  // ---------------------------------------------------------------- model
  typedef struct {
    logic        valid, flush;
    logic [31:0] pc, alu, rs2;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic        ruw, dmw;
    logic [2:0]  ctrl;
  } instr_t;

  typedef struct {
    logic        full;
    logic        chk_data;
    logic [31:0] pc, alu, data;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic        ruw;
    logic        trap;
  } wb_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_nbytes(input logic [2:0] ctrl);
    if (ctrl[1:0] == 2'b00) return 1;
    if (ctrl[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_is_mem(input instr_t i);
    return i.valid && !i.flush && (i.dmw || i.src == 2'b01);
  endfunction

  // Byte offset of the accessed lane: address rounded down to the access size.
  function automatic int m_off(input instr_t i);
    int a = int'(i.alu[1:0]);
    return a - (a % m_nbytes(i.ctrl));
  endfunction

  function automatic bit m_mis(input instr_t i);
`ifdef MISALIGN_TRAP_EN
    int n = m_nbytes(i.ctrl);
    return m_is_mem(i) && n > 1 && (int'(i.alu[1:0]) % n) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] m_be(input instr_t i);
    int n = m_nbytes(i.ctrl);
    if (!i.dmw) return 4'hF;
    return 4'(((1 << n) - 1) << m_off(i));
  endfunction

  function automatic logic [31:0] m_wdata(input instr_t i);
    int n = m_nbytes(i.ctrl);
    if (n == 1) return 32'(i.rs2[7:0]) * 32'h0101_0101;
    if (n == 2) return 32'(i.rs2[15:0]) * 32'h0001_0001;
    return i.rs2;
  endfunction

  function automatic logic [31:0] m_load(input instr_t i, input logic [31:0] rdata);
    int n = m_nbytes(i.ctrl);
    longint unsigned lim, v;
    lim = 64'd1 << (8 * n);
    v   = (64'(rdata) >> (8 * m_off(i))) % lim;
    if (!i.ctrl[2] && n < 4 && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  // ---------------------------------------------------------------- compare process
  logic        cmp_en = 1'b0;
  logic        exp_wb_on = 1'b0;
  logic        exp_req, exp_we, exp_stall;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  wb_t         exp_wb;

  always @(negedge clk_mem) begin
    if (cmp_en) begin
      chk("dm_req", 32'(dm_bus.dm_req), 32'(exp_req));
      chk("stall_mem", 32'(stall_mem), 32'(exp_stall));
      if (exp_req) begin
        chk("dm_we", 32'(dm_bus.dm_we), 32'(exp_we));
        chk("dm_addr", dm_bus.dm_addr, exp_addr);
        chk("dm_be", 32'(dm_bus.dm_be), 32'(exp_be));
        if (exp_we) chk("dm_wdata", dm_bus.dm_wdata, exp_wdata);
      end
      if (exp_wb_on) begin
        chk("RUwrite_wb", 32'(RUwrite_wb), 32'(exp_wb.ruw));
        chk("rd_wb", 32'(rd_wb), 32'(exp_wb.rd));
`ifdef MISALIGN_TRAP_EN
        chk("misalign_trap_wb", 32'(misalign_trap_wb), 32'(exp_wb.trap));
`endif
        if (exp_wb.full) begin
          chk("pc_next_wb", pc_next_wb, exp_wb.pc);
          chk("ALU_res_wb", ALU_res_wb, exp_wb.alu);
          chk("RU_DM_write_src_wb", 32'(RU_DM_write_src_wb), 32'(exp_wb.src));
          if (exp_wb.chk_data) chk("DM_data_rd_wb", DM_data_rd_wb, exp_wb.data);
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  logic        obs_req, obs_we;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  int          obs_stalls, obs_bubbles;

  // Called at posedge+1; returns at posedge+1 after the committing edge.
  task automatic run_instr(input instr_t i, input int d, input logic [31:0] rdata, input bit flush_in_wait);
    bit iss  = m_is_mem(i) && !m_mis(i);
    int last = iss ? d : 0;
    wb_t bub = '{full: 1'b0, chk_data: 1'b0, pc: '0, alu: '0, data: '0, rd: '0, src: '0, ruw: 1'b0, trap: 1'b0};
    obs_stalls  = 0;
    obs_bubbles = 0;
    for (int k = 0; k <= last; k++) begin
      valid_mem           = i.valid;
      flush_mem           = (k > 0 && flush_in_wait) ? 1'b1 : i.flush;
      pc_next_mem         = i.pc;
      ALU_res_mem         = i.alu;
      rs2_data_mem        = i.rs2;
      rd_mem              = i.rd;
      RU_DM_write_src_mem = i.src;
      RUwrite_mem         = i.ruw;
      DMwrite_mem         = i.dmw;
      DMctrl_mem          = i.ctrl;
      dm_bus.dm_ack       = iss ? (k == d) : 1'($urandom_range(0, 1));
      dm_bus.dm_rdata     = (iss && k == d) ? rdata : $urandom;
      exp_req   = iss;
      exp_stall = iss && (k < d);
      exp_we    = i.dmw;
      exp_addr  = {i.alu[31:2], 2'b00};
      exp_be    = m_be(i);
      exp_wdata = m_wdata(i);
      @(negedge clk_mem);
      if (k == 0) begin
        obs_req   = dm_bus.dm_req;
        obs_we    = dm_bus.dm_we;
        obs_be    = dm_bus.dm_be;
        obs_wdata = dm_bus.dm_wdata;
      end
      if (stall_mem) obs_stalls++;
      @(posedge clk_mem);
      #1;
      if (!RUwrite_wb && rd_wb == 5'd0) obs_bubbles++;
      if ((iss && k < d) || !(i.valid && !i.flush)) begin
        exp_wb = bub;
      end else begin
        exp_wb.full     = 1'b1;
        exp_wb.pc       = i.pc;
        exp_wb.alu      = i.alu;
        exp_wb.rd       = i.rd;
        exp_wb.src      = i.src;
        exp_wb.trap     = m_mis(i);
        exp_wb.ruw      = i.ruw && (i.rd != 5'd0) && !m_mis(i);
        exp_wb.chk_data = (i.src == 2'b01) && !m_mis(i);
        exp_wb.data     = m_load(i, rdata);
      end
      exp_wb_on = 1'b1;
    end
  endtask

  function automatic instr_t mk(input logic [1:0] src, input logic dmw, input logic [2:0] ctrl,
                                input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                                input logic ruw);
    instr_t i;
    i.valid = 1'b1; i.flush = 1'b0; i.pc = 32'h0000_1004; i.alu = alu; i.rs2 = rs2;
    i.rd = rd; i.src = src; i.ruw = ruw; i.dmw = dmw; i.ctrl = ctrl;
    return i;
  endfunction

  // ---------------------------------------------------------------- main
  initial begin
    instr_t      i;
    logic [2:0]  ld_ctrls [5];
    ld_ctrls = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    rst_mem = 1'b1;
    valid_mem = 1'b0; flush_mem = 1'b0; pc_next_mem = '0; ALU_res_mem = '0; rs2_data_mem = '0;
    rd_mem = '0; RU_DM_write_src_mem = '0; RUwrite_mem = 1'b0; DMwrite_mem = 1'b0; DMctrl_mem = '0;
    dm_bus.dm_ack = 1'b0; dm_bus.dm_rdata = '0;
    repeat (2) @(posedge clk_mem);
    #1;
    chk("rst_dm_req", 32'(dm_bus.dm_req), 32'd0);
    chk("rst_stall", 32'(stall_mem), 32'd0);
    chk("rst_RUwrite_wb", 32'(RUwrite_wb), 32'd0);
    chk("rst_DM_data_rd_wb", DM_data_rd_wb, 32'd0);
    rst_mem = 1'b0;
    cmp_en  = 1'b1;

    // LW 0x100, zero-wait
    i = mk(2'b01, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd7, 1'b1);
    run_instr(i, 0, 32'hDEAD_BEEF, 1'b0);
    chk("lw_stall_cycles", 32'(obs_stalls), 32'd0);
    chk("lw_data", DM_data_rd_wb, 32'hDEAD_BEEF);

    // LB 0x103, ack after 3 stall cycles
    i = mk(2'b01, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd9, 1'b1);
    run_instr(i, 3, 32'h80FF_0000, 1'b0);
    chk("lb_stall_cycles", 32'(obs_stalls), 32'd3);
    chk("lb_bubbles", 32'(obs_bubbles), 32'd3);
    chk("lb_data", DM_data_rd_wb, 32'hFFFF_FF80);

    // SH 0x202
    i = mk(2'b00, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd0, 1'b0);
    run_instr(i, 1, 32'h0, 1'b0);
    chk("sh_we", 32'(obs_we), 32'd1);
    chk("sh_be", 32'(obs_be), 32'b1100);
    chk("sh_wdata", obs_wdata, 32'hABCD_ABCD);

    // ALU op, rd=0 then rd=5
    i = mk(2'b00, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd0, 1'b1);
    run_instr(i, 0, 32'h0, 1'b0);
    chk("alu_rd0_RUwrite", 32'(RUwrite_wb), 32'd0);
    i = mk(2'b00, 1'b0, 3'b000, 32'h0000_0077, 32'h0, 5'd5, 1'b1);
    run_instr(i, 0, 32'h0, 1'b0);
    chk("alu_rd5_req", 32'(obs_req), 32'd0);
    chk("alu_rd5_RUwrite", 32'(RUwrite_wb), 32'd1);
    chk("alu_rd5_ALU_res", ALU_res_wb, 32'h0000_0077);

`ifdef MISALIGN_TRAP_EN
    i = mk(2'b01, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd3, 1'b1);
    run_instr(i, 0, 32'h0, 1'b0);
    chk("mis_req", 32'(obs_req), 32'd0);
    chk("mis_trap", 32'(misalign_trap_wb), 32'd1);
    chk("mis_RUwrite", 32'(RUwrite_wb), 32'd0);
    i = mk(2'b00, 1'b0, 3'b000, 32'h0000_0010, 32'h0, 5'd4, 1'b1);
    run_instr(i, 0, 32'h0, 1'b0);
    chk("mis_trap_one_cycle", 32'(misalign_trap_wb), 32'd0);
`endif

    // Random instruction stream
    for (int n = 0; n < 400; n++) begin
      int kind = $urandom_range(0, 3);
      i.valid = ($urandom_range(0, 9) != 0);
      i.flush = ($urandom_range(0, 9) == 0);
      i.pc    = $urandom;
      i.alu   = $urandom;
      i.rs2   = $urandom;
      i.rd    = 5'($urandom_range(0, 31));
      i.ruw   = 1'($urandom_range(0, 1));
      case (kind)
        0: begin i.src = 2'b01; i.dmw = 1'b0; i.ctrl = ld_ctrls[$urandom_range(0, 4)]; end
        1: begin i.src = 2'b00; i.dmw = 1'b1; i.ctrl = 3'($urandom_range(0, 2)); i.ruw = 1'b0; end
        2: begin i.src = 2'b00; i.dmw = 1'b0; i.ctrl = 3'($urandom_range(0, 7)); end
        default: begin i.src = 2'b10; i.dmw = 1'b0; i.ctrl = 3'($urandom_range(0, 7)); end
      endcase
      run_instr(i, $urandom_range(0, 3), $urandom, ($urandom_range(0, 3) == 0));
    end

    // Reset while waiting for an ack
    cmp_en    = 1'b0;
    exp_wb_on = 1'b0;
    valid_mem = 1'b1; flush_mem = 1'b0; ALU_res_mem = 32'h0000_0300; rd_mem = 5'd6;
    RU_DM_write_src_mem = 2'b01; RUwrite_mem = 1'b1; DMwrite_mem = 1'b0; DMctrl_mem = 3'b010;
    pc_next_mem = 32'h0000_2004;
    dm_bus.dm_ack = 1'b0;
    @(posedge clk_mem);
    #1;
    chk("wait_stall", 32'(stall_mem), 32'd1);
    chk("wait_req", 32'(dm_bus.dm_req), 32'd1);
    rst_mem = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_mem);
      #1;
      chk("rstw_dm_req", 32'(dm_bus.dm_req), 32'd0);
      chk("rstw_stall", 32'(stall_mem), 32'd0);
      chk("rstw_pc_next_wb", pc_next_wb, 32'd0);
      chk("rstw_ALU_res_wb", ALU_res_wb, 32'd0);
      chk("rstw_DM_data_rd_wb", DM_data_rd_wb, 32'd0);
      chk("rstw_rd_wb", 32'(rd_wb), 32'd0);
      chk("rstw_src_wb", 32'(RU_DM_write_src_wb), 32'd0);
      chk("rstw_RUwrite_wb", 32'(RUwrite_wb), 32'd0);
    end
    rst_mem   = 1'b0;
    valid_mem = 1'b0;
    dm_bus.dm_ack = 1'b1;
    @(posedge clk_mem);
    #1;
    chk("stray_ack_req", 32'(dm_bus.dm_req), 32'd0);
    chk("stray_ack_stall", 32'(stall_mem), 32'd0);
    chk("stray_ack_RUwrite", 32'(RUwrite_wb), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
